// File: rtl/bram_dp_param.sv
// Parametrised true-dual-port block RAM with byte enables, a post-reset clear engine and
// selectable same-port read-during-write. Optional BRAM_OUTREG_EN adds an output register stage.
module bram_dp_param #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 10,
  parameter int                BYTE_W     = 8,
  parameter int                WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL   = '0,
  localparam int               NB         = DATA_W / BYTE_W
) (
  input  logic              clka_0,
  input  logic              rsta_0,
  input  logic              ena_0,
  input  logic [NB-1:0]     wea_0,
  input  logic [ADDR_W-1:0] addra_0,
  input  logic [DATA_W-1:0] dina_0,
  output logic [DATA_W-1:0] douta_0,
  input  logic              enb_0,
  input  logic [NB-1:0]     web_0,
  input  logic [ADDR_W-1:0] addrb_0,
  input  logic [DATA_W-1:0] dinb_0,
  output logic [DATA_W-1:0] doutb_0,
  output logic              init_busy_0
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              live, en_a, en_b;
  logic [DATA_W-1:0] rd_a, rd_b;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0]     we);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    return r;
  endfunction

  always_ff @(posedge clka_0) begin
    if (rsta_0) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == '1) state_d = RUN;
    end
  end

  assign live        = (state_q == RUN);
  assign init_busy_0 = ~live;
  assign en_a        = live & ena_0;
  assign en_b        = live & enb_0;

  // Reads always see the stored word; only the own port's lanes can be forwarded (write-first).
  assign rd_a = (WRITE_MODE == 1) ? merge(mem[addra_0], dina_0, wea_0) : mem[addra_0];
  assign rd_b = (WRITE_MODE == 1) ? merge(mem[addrb_0], dinb_0, web_0) : mem[addrb_0];

  // Port B lanes are issued first so that port A wins any lane both ports write.
  always_ff @(posedge clka_0) begin
    if (!rsta_0) begin
      if (!live) begin
        mem[clr_q] <= INIT_VAL;
      end else begin
        for (int i = 0; i < NB; i++)
          if (en_b && web_0[i]) mem[addrb_0][i*BYTE_W +: BYTE_W] <= dinb_0[i*BYTE_W +: BYTE_W];
        for (int i = 0; i < NB; i++)
          if (en_a && wea_0[i]) mem[addra_0][i*BYTE_W +: BYTE_W] <= dina_0[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef BRAM_OUTREG_EN
  logic [DATA_W-1:0] q1a, q1b;
  logic              v1a, v1b;

  always_ff @(posedge clka_0) begin
    if (rsta_0) begin
      q1a     <= '0;
      q1b     <= '0;
      v1a     <= 1'b0;
      v1b     <= 1'b0;
      douta_0 <= '0;
      doutb_0 <= '0;
    end else begin
      v1a <= en_a;
      v1b <= en_b;
      if (en_a) q1a <= rd_a;
      if (en_b) q1b <= rd_b;
      if (v1a) douta_0 <= q1a;
      if (v1b) doutb_0 <= q1b;
    end
  end
`else
  always_ff @(posedge clka_0) begin
    if (rsta_0) begin
      douta_0 <= '0;
      doutb_0 <= '0;
    end else begin
      if (en_a) douta_0 <= rd_a;
      if (en_b) doutb_0 <= rd_b;
    end
  end
`endif

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: directed test-plan steps plus randomized dual-port traffic
// checked cycle by cycle against a word-array model of the memory.
module tb_bram_dp_param;

  localparam int WM = 0;

  logic        clk = 1'b0;
  logic        rsta_0 = 1'b0;
  logic        ena_0 = 1'b0, enb_0 = 1'b0;
  logic [1:0]  wea_0 = '0, web_0 = '0;
  logic [9:0]  addra_0 = '0, addrb_0 = '0;
  logic [15:0] dina_0 = '0, dinb_0 = '0;
  logic [15:0] douta_0, doutb_0;
  logic        init_busy_0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] mm [1024];
  logic [15:0] ea = '0, eb = '0, pa = '0, pb = '0;
  logic        pva = 1'b0, pvb = 1'b0;

  bram_dp_param #(.DATA_W(16), .ADDR_W(10), .BYTE_W(8), .WRITE_MODE(WM), .INIT_VAL(16'h0000)) dut (
    .clka_0(clk), .rsta_0(rsta_0),
    .ena_0(ena_0), .wea_0(wea_0), .addra_0(addra_0), .dina_0(dina_0), .douta_0(douta_0),
    .enb_0(enb_0), .web_0(web_0), .addrb_0(addrb_0), .dinb_0(dinb_0), .doutb_0(doutb_0),
    .init_busy_0(init_busy_0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lanes(input logic [15:0] old_w, input logic [15:0] d,
                                        input logic [1:0] we);
    logic [15:0] r;
    r = old_w;
    for (int l = 0; l < 2; l++)
      if (we[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  // One clock of port traffic; model predicts reads before applying writes (B then A).
  task automatic cycle(input logic a_en, input logic [1:0] a_we, input logic [9:0] a_ad,
                       input logic [15:0] a_d, input logic b_en, input logic [1:0] b_we,
                       input logic [9:0] b_ad, input logic [15:0] b_d);
    logic [15:0] ra, rb;
    ena_0 = a_en; wea_0 = a_we; addra_0 = a_ad; dina_0 = a_d;
    enb_0 = b_en; web_0 = b_we; addrb_0 = b_ad; dinb_0 = b_d;
    ra = (WM == 1) ? lanes(mm[a_ad], a_d, a_we) : mm[a_ad];
    rb = (WM == 1) ? lanes(mm[b_ad], b_d, b_we) : mm[b_ad];
    if (b_en) mm[b_ad] = lanes(mm[b_ad], b_d, b_we);
    if (a_en) mm[a_ad] = lanes(mm[a_ad], a_d, a_we);
    @(posedge clk); #1;
`ifdef BRAM_OUTREG_EN
    if (pva) ea = pa;
    if (pvb) eb = pb;
    if (a_en) pa = ra;
    if (b_en) pb = rb;
    pva = a_en;
    pvb = b_en;
`else
    if (a_en) ea = ra;
    if (b_en) eb = rb;
`endif
    check("douta_model", douta_0, ea);
    check("doutb_model", doutb_0, eb);
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 10'd0, 16'h0, 1'b0, 2'b00, 10'd0, 16'h0);
  endtask

  task automatic read_a(input logic [9:0] ad, input logic [15:0] exp);
    cycle(1'b1, 2'b00, ad, 16'h0, 1'b0, 2'b00, 10'd0, 16'h0);
    idle();
    check("read_a", douta_0, exp);
  endtask

  task automatic read_b(input logic [9:0] ad, input logic [15:0] exp);
    cycle(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 2'b00, ad, 16'h0);
    idle();
    check("read_b", doutb_0, exp);
  endtask

  task automatic do_reset();
    rsta_0 = 1'b1;
    ena_0 = 1'b0; enb_0 = 1'b0; wea_0 = '0; web_0 = '0;
    @(posedge clk); #1;
    check("rst_busy", 16'(init_busy_0), 16'd1);
    check("rst_douta", douta_0, 16'h0);
    check("rst_doutb", doutb_0, 16'h0);
    rsta_0 = 1'b0;
    ea = '0; eb = '0; pa = '0; pb = '0; pva = 1'b0; pvb = 1'b0;
  endtask

  // Drives (optionally) hostile writes to already-cleared words while busy.
  task automatic run_busy(input logic poke, input int limit, output int n);
    n = 0;
    while (init_busy_0 && n < limit) begin
      ena_0 = poke; wea_0 = {2{poke}}; addra_0 = 10'd0; dina_0 = 16'hFFFF;
      enb_0 = poke; web_0 = {2{poke}}; addrb_0 = 10'd1; dinb_0 = 16'hFFFF;
      @(posedge clk); #1;
      n++;
      if (poke) check("busy_dout", douta_0 | doutb_0, 16'h0);
    end
    ena_0 = 1'b0; enb_0 = 1'b0; wea_0 = '0; web_0 = '0;
  endtask

  task automatic wait_clear(input logic poke);
    int n;
    run_busy(poke, 3000, n);
    check("busy_cycles", 16'(n), 16'd1024);
    for (int i = 0; i < 1024; i++) mm[i] = 16'h0000;
    check("post_clear_douta", douta_0, 16'h0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    wait_clear(1'b0);
    read_a(10'd0, 16'h0000);
    read_a(10'd511, 16'h0000);
    read_b(10'd1023, 16'h0000);

    cycle(1'b1, 2'b11, 10'd2, 16'd23, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b1, 2'b11, 10'd3, 16'd45, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b1, 2'b11, 10'd1, 16'd50, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b1, 2'b00, 10'd1, 16'h0, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b1, 2'b00, 10'd2, 16'h0, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b1, 2'b00, 10'd3, 16'h0, 1'b0, 2'b00, 10'd0, 16'h0);
    idle();
    idle();
    read_a(10'd1, 16'd50);
    read_a(10'd2, 16'd23);
    read_a(10'd3, 16'd45);

    cycle(1'b1, 2'b11, 10'd5, 16'hABCD, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 2'b01, 10'd5, 16'h1234);
    idle();
    check("same_port_rdw", doutb_0, (WM == 1) ? 16'hAB34 : 16'hABCD);
    read_b(10'd5, 16'hAB34);

    cycle(1'b1, 2'b10, 10'd7, 16'h1111, 1'b1, 2'b11, 10'd7, 16'h2222);
    read_a(10'd7, 16'h1122);

    cycle(1'b1, 2'b11, 10'd9, 16'h0F0F, 1'b0, 2'b00, 10'd0, 16'h0);
    cycle(1'b1, 2'b11, 10'd9, 16'h5555, 1'b1, 2'b00, 10'd9, 16'h0);
    idle();
    check("cross_port_rdw", doutb_0, 16'h0F0F);
    read_b(10'd9, 16'h5555);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10'($urandom_range(0, 15)),
            16'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            10'($urandom_range(0, 15)), 16'($urandom));
    for (int a = 0; a < 16; a++) read_a(10'(a), mm[a]);

    do_reset();
    run_busy(1'b1, 500, n);
    do_reset();
    wait_clear(1'b1);
    read_a(10'd0, 16'h0000);
    read_b(10'd1, 16'h0000);

    cycle(1'b1, 2'b11, 10'd4, 16'h7777, 1'b0, 2'b00, 10'd0, 16'h0);
    read_a(10'd4, 16'h7777);
    do_reset();
    wait_clear(1'b0);
    read_a(10'd4, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bram_dp_param.md
Name: bram_dp_param

Overview:
Parametrised true-dual-port block RAM. It is the successor to the single-port 1Kx16 block RAM wrapper. Two independent read/write ports share one clock and support byte-enables plus a selectable same-port write mode. A post-reset clear engine fills every word with INIT_VAL before the ports go live. Used as scratch/data memory by the datapath and as a shared buffer between producer and consumer logic.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of BYTE_W
ADDR_W, 10, address width; depth = 2**ADDR_W words
BYTE_W, 8, bits per write-enable lane; NB = DATA_W/BYTE_W lanes
WRITE_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
INIT_VAL, 0, word value written to every location by the clear engine

Ports:
clka_0  in  1  clock for both ports
rsta_0  in  1  synchronous active-high reset
ena_0  in  1  port A enable
wea_0  in  NB  port A byte write enables; zero means read
addra_0  in  ADDR_W  port A address
dina_0  in  DATA_W  port A write data
douta_0  out  DATA_W  port A read data
enb_0  in  1  port B enable
web_0  in  NB  port B byte write enables
addrb_0  in  ADDR_W  port B address
dinb_0  in  DATA_W  port B write data
doutb_0  out  DATA_W  port B read data
init_busy_0  out  1  high while the clear engine runs; ports are ignored

Behaviour:
- Reset: rsta_0 sampled high at a clka_0 edge sets douta_0=0, doutb_0=0 and init_busy_0=1, and puts the FSM in CLEAR with clr_addr=0. Memory contents are not touched by reset itself.
- FSM CLEAR:
  - Each cycle writes INIT_VAL to clr_addr, then clr_addr+1.
  - After writing address 2**ADDR_W-1 it moves to RUN and drops init_busy_0 on the following edge. Total busy time is exactly 2**ADDR_W cycles after reset deasserts.
  - ena_0/enb_0 are ignored and outputs hold 0.
- FSM RUN: normal access. RUN never returns to CLEAR except via rsta_0.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from address 0. Any in-flight port write on that edge is dropped.
- Port access in RUN, for each port independently:
  - enable=0: no write, dout holds its value.
  - enable=1: lane i (bits i*BYTE_W+:BYTE_W) is written when we[i]=1; other lanes keep old contents.
  - dout updates 1 cycle after the address edge.
  - Same-port read-during-write: WRITE_MODE=0 returns pre-write word. WRITE_MODE=1 returns merged post-write word (written lanes new, others old).
- Cross-port collisions, same address in the same cycle:
  - Both ports write: per lane, port A wins wherever wea_0[i]=1; port B lanes apply only where wea_0[i]=0.
  - One port writes, other reads: the reader gets the old word (read-first across ports) regardless of WRITE_MODE.
- Address range is full power of two, so no out-of-range case exists; the address does not wrap within a port.

Optional Feature:
Macro BRAM_OUTREG_EN.
- Defined: an extra output register stage on each port. Read latency is 2 cycles, and douta_0/doutb_0 reset to 0. The output register updates every cycle in which the pipeline stage-1 enable was high, so data follows the address by exactly 2 edges.
- Undefined: latency 1 as above, with no extra flops.
- Collision and WRITE_MODE rules are unchanged. Only latency shifts.

Test Plan:
- Reset, then hold ena/enb=0 -> init_busy_0 high for exactly 1024 cycles, then 0. Read of addresses 0, 511 and 1023 returns 0x0000.
- Port A writes 23@2, 45@3, 50@1 (wea_0=2'b11), then reads 1,2,3 -> douta_0 = 50, 23, 45, each 1 cycle after its address (2 with BRAM_OUTREG_EN).
- Word at 5 = 0xABCD; port B writes 0x1234 with web_0=2'b01 -> read 5 gives 0xAB34. In the write cycle itself, doutb_0 is 0xABCD (WRITE_MODE=0) or 0xAB34 (WRITE_MODE=1).
- Same cycle at address 7: A writes 0x1111 (wea_0=2'b10), B writes 0x2222 (web_0=2'b11) -> location 7 = 0x1122.
- Same cycle at address 9 (holding 0x0F0F): A writes 0x5555, B reads 9 -> doutb_0=0x0F0F. The next read of 9 gives 0x5555.
- Assert rsta_0 for 1 cycle midway through CLEAR and again in RUN after writing 0x7777@4 -> CLEAR restarts from 0 with a full 1024-cycle busy window. Afterwards, address 4 reads INIT_VAL.
